// File: rtl/apb_req_mgr_if.sv
// rtl/apb_req_mgr_if.sv - request/response/APB3 signal bundle for apb_req_mgr
interface apb_req_mgr_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [AddrWidth-1:0] req_addr_i;
  logic                 req_write_i;
  logic [DataWidth-1:0] req_wdata_i;

  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [DataWidth-1:0] rsp_rdata_o;
  logic                 rsp_err_o;

  logic [AddrWidth-1:0] paddr_o;
  logic                 pwrite_o;
  logic [DataWidth-1:0] pwdata_o;
  logic                 psel_o;
  logic                 penable_o;
  logic [DataWidth-1:0] prdata_i;
  logic                 pready_i;
  logic                 pslverr_i;

  // The request manager itself.
  modport slave (
    input  req_valid_i, req_addr_i, req_write_i, req_wdata_i,
    output req_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  rsp_ready_i,
    output paddr_o, pwrite_o, pwdata_o, psel_o, penable_o,
    input  prdata_i, pready_i, pslverr_i
  );

  // The environment: requester, response consumer and APB completer.
  modport master (
    output req_valid_i, req_addr_i, req_write_i, req_wdata_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output rsp_ready_i,
    input  paddr_o, pwrite_o, pwdata_o, psel_o, penable_o,
    output prdata_i, pready_i, pslverr_i
  );
endinterface

// File: rtl/apb_req_mgr.sv
// rtl/apb_req_mgr.sv - single-request APB3 manager; optional ACCESS timeout under APB_TIMEOUT_EN
module apb_req_mgr #(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 255
) (
  input logic          clk_i,
  input logic          rst_ni,
  apb_req_mgr_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] paddr_q, paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic [DataWidth-1:0] pwdata_q, pwdata_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;

`ifdef APB_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TimeoutCycles);
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TimeoutCycles);
`endif

  // State and all outputs are registered; reset abandons any transfer in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Next state and next registered outputs; APB inputs only matter in ACCESS.
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
    cnt_d       = cnt_q;
    cnt_inc     = cnt_q + CntW'(1);
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          paddr_d  = bus.req_addr_i;
          pwrite_d = bus.req_write_i;
          pwdata_d = bus.req_wdata_i;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (bus.pready_i) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.pslverr_i;
          rsp_rdata_d = pwrite_q ? '0 : bus.prdata_i;
          state_d     = RESP;
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_inc == TimeoutVal) begin
          // Completer never answered: close the transfer with an error.
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          cnt_d       = cnt_inc;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.paddr_o     = paddr_q;
  assign bus.pwrite_o    = pwrite_q;
  assign bus.pwdata_o    = pwdata_q;
  assign bus.psel_o      = psel_q;
  assign bus.penable_o   = penable_q;

endmodule

// File: tb/tb_apb_req_mgr.sv
// tb/tb_apb_req_mgr.sv - vector table plus scoreboard bench for apb_req_mgr
module tb_apb_req_mgr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_req_mgr_if #(.AddrWidth(32), .DataWidth(32)) bus ();

  apb_req_mgr #(.AddrWidth(32), .DataWidth(32), .TimeoutCycles(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wait_cyc;
    logic        tie_ready;
    logic [31:0] prdata;
    logic        slverr;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  vec_t        vecs[5];
  rsp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          cur_wait = 0;
  logic        tie_ready = 1'b0;
  logic [31:0] exp_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: score a response handshake, advance, then check protocol and update the completer.
  task automatic step();
    rsp_t e;
    if (bus.rsp_valid_o && bus.rsp_ready_i) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_rdata", bus.rsp_rdata_o, e.rdata);
        chk("rsp_err", bus.rsp_err_o, e.err);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (bus.penable_o) chk("penable_needs_psel", bus.psel_o, 1);
    if (bus.psel_o) chk("paddr_stable", bus.paddr_o, exp_addr);
    if (bus.psel_o && bus.penable_o) acc_cnt++;
    else acc_cnt = 0;
    bus.pready_i = tie_ready || (bus.psel_o && bus.penable_o && acc_cnt > cur_wait);
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 50 && !bus.req_ready_o; k++) step();
    chk("req_ready_wait", bus.req_ready_o, 1);
  endtask

  task automatic run_txn(input vec_t v);
    rsp_t e;
    int   acc_c;
    int   pen;
    cur_wait        = v.wait_cyc;
    tie_ready       = v.tie_ready;
    bus.prdata_i    = v.prdata;
    bus.pslverr_i   = v.slverr;
    bus.req_write_i = v.write;
    bus.req_addr_i  = v.addr;
    bus.req_wdata_i = v.wdata;
    bus.req_valid_i = 1'b1;
    bus.rsp_ready_i = 1'b0;
    wait_ready();
    e.rdata  = v.exp_rdata;
    e.err    = v.exp_err;
    sb.push_back(e);
    exp_addr = v.addr;
    acc_c    = cyc;
    step();
    bus.req_valid_i = 1'b0;
    chk("setup_psel", bus.psel_o, 1);
    chk("setup_penable", bus.penable_o, 0);
    chk("setup_pwrite", bus.pwrite_o, v.write);
    chk("setup_pwdata", bus.pwdata_o, v.wdata);
    pen = 0;
    for (int k = 0; k < 200 && !bus.rsp_valid_o; k++) begin
      if (bus.penable_o) pen++;
      step();
    end
    chk("rsp_valid_seen", bus.rsp_valid_o, 1);
    chk("penable_cycles", pen, v.wait_cyc + 1);
    chk("latency", cyc - acc_c, v.wait_cyc + 3);
    chk("resp_psel", bus.psel_o, 0);
    for (int k = 0; k < v.hold; k++) begin
      chk("hold_valid", bus.rsp_valid_o, 1);
      chk("hold_rdata", bus.rsp_rdata_o, v.exp_rdata);
      chk("hold_err", bus.rsp_err_o, v.exp_err);
      chk("hold_req_ready", bus.req_ready_o, 0);
      step();
    end
    bus.rsp_ready_i = 1'b1;
    step();
    bus.rsp_ready_i = 1'b0;
    chk("after_rsp_valid", bus.rsp_valid_o, 0);
    chk("after_req_ready", bus.req_ready_o, 1);
  endtask

  initial begin
    rsp_t e;
    int   s1, s2;
    logic seen;

    //          wr    addr          wdata         wait tie   prdata        err   hold exp_rdata     exp_err
    vecs[0] = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0,  1'b1, 32'hAAAA_5555, 1'b0, 0, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_2004, 32'h0000_0000, 3,  1'b0, 32'h1234_5678, 1'b0, 0, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_3008, 32'h0000_0000, 0,  1'b0, 32'hCAFE_F00D, 1'b1, 5, 32'hCAFE_F00D, 1'b1};
    vecs[3] = '{1'b1, 32'h0000_400C, 32'h0BAD_CAFE, 2,  1'b0, 32'h7777_7777, 1'b1, 1, 32'h0000_0000, 1'b1};
    vecs[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1,  1'b0, 32'hFFFF_FFFF, 1'b0, 2, 32'hFFFF_FFFF, 1'b0};

    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_write_i = 1'b0;
    bus.req_wdata_i = '0;
    bus.rsp_ready_i = 1'b0;
    bus.prdata_i    = '0;
    bus.pready_i    = 1'b0;
    bus.pslverr_i   = 1'b0;

    step();
    step();
    rst_n = 1'b1;
    chk("rst_psel", bus.psel_o, 0);
    chk("rst_penable", bus.penable_o, 0);
    chk("rst_pwrite", bus.pwrite_o, 0);
    chk("rst_paddr", bus.paddr_o, 0);
    chk("rst_pwdata", bus.pwdata_o, 0);
    chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata_o, 0);
    chk("rst_rsp_err", bus.rsp_err_o, 0);
    chk("rst_req_ready", bus.req_ready_o, 1);

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Back-to-back: request held valid, consumer always ready.
    tie_ready       = 1'b0;
    cur_wait        = 0;
    bus.pslverr_i   = 1'b0;
    bus.prdata_i    = 32'h2222_2222;
    bus.rsp_ready_i = 1'b1;
    bus.req_write_i = 1'b1;
    bus.req_addr_i  = 32'h0000_5000;
    bus.req_wdata_i = 32'h1111_1111;
    bus.req_valid_i = 1'b1;
    wait_ready();
    e.rdata = 32'h0; e.err = 1'b0;
    sb.push_back(e);
    exp_addr = 32'h0000_5000;
    step();
    s1 = cyc;
    bus.req_write_i = 1'b0;
    bus.req_addr_i  = 32'h0000_5004;
    bus.req_wdata_i = 32'h0;
    for (int k = 0; k < 20; k++) begin
      if (bus.req_ready_o) begin
        e.rdata = 32'h2222_2222; e.err = 1'b0;
        sb.push_back(e);
        exp_addr = 32'h0000_5004;
      end
      step();
      if (bus.psel_o && !bus.penable_o) break;
    end
    s2 = cyc;
    bus.req_valid_i = 1'b0;
    chk("b2b_setup_gap", s2 - s1, 4);
    chk("b2b_paddr", bus.paddr_o, 32'h0000_5004);
    for (int k = 0; k < 20 && sb.size() != 0; k++) step();
    chk("b2b_sb_drained", sb.size(), 0);
    bus.rsp_ready_i = 1'b0;
    step();

    // Reset in the middle of ACCESS drops the transfer.
    cur_wait        = 20;
    bus.req_write_i = 1'b0;
    bus.req_addr_i  = 32'h0000_7000;
    bus.req_valid_i = 1'b1;
    wait_ready();
    exp_addr = 32'h0000_7000;
    step();
    bus.req_valid_i = 1'b0;
    step();
    step();
    chk("mid_access_penable", bus.penable_o, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_mid_psel", bus.psel_o, 0);
    chk("rst_mid_penable", bus.penable_o, 0);
    chk("rst_mid_rsp_valid", bus.rsp_valid_o, 0);
    chk("rst_mid_req_ready", bus.req_ready_o, 1);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.rsp_valid_o) seen = 1'b1;
    end
    chk("rst_no_response", seen, 0);

    // Completer stuck with pready low.
    cur_wait        = 100000;
    bus.prdata_i    = 32'h5A5A_5A5A;
    bus.req_addr_i  = 32'h0000_6000;
    bus.req_write_i = 1'b0;
    bus.req_valid_i = 1'b1;
    wait_ready();
    exp_addr = 32'h0000_6000;
`ifdef APB_TIMEOUT_EN
    e.rdata = 32'h0; e.err = 1'b1;
    sb.push_back(e);
    step();
    bus.req_valid_i = 1'b0;
    s1 = 0;
    for (int k = 0; k < 100 && !bus.rsp_valid_o; k++) begin
      if (bus.penable_o) s1++;
      step();
    end
    chk("timeout_valid", bus.rsp_valid_o, 1);
    chk("timeout_access_cycles", s1, 8);
    chk("timeout_psel", bus.psel_o, 0);
    bus.rsp_ready_i = 1'b1;
    step();
    bus.rsp_ready_i = 1'b0;
    chk("timeout_sb_drained", sb.size(), 0);
`else
    step();
    bus.req_valid_i = 1'b0;
    for (int k = 0; k < 1000; k++) step();
    chk("no_timeout_psel", bus.psel_o, 1);
    chk("no_timeout_penable", bus.penable_o, 1);
    chk("no_timeout_rsp_valid", bus.rsp_valid_o, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("recover_req_ready", bus.req_ready_o, 1);
`endif
    cur_wait = 0;
    step();
    chk("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
